key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
- Dynamic work distributor for parallel RC4 key-search cores. Each core runs its own init/swap/decrypt loops and character checker.
- Hands out contiguous key chunks on request via a round-robin grant, tracks the global next-key pointer and collects found/exhausted status.
- Broadcasts stop to all cores once any core reports a valid key.
- Sits between the top-level control (start, LEDs) and N instances of the per-core search datapath.

Parameters:
- NUM_CORES, 4, number of search cores served (2..8).
- KEY_W, 24, key width in bits.
- KEY_MAX, 24'h3FFFFF, highest key searched (inclusive).
- CHUNK_SIZE, 4096, keys per grant; power of two, at least 1.

Ports:
- clok  in  1  system clock.
- resetm  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a search from key 0.
- core_req  in  NUM_CORES  per-core chunk request; held until granted.
- core_busy  in  NUM_CORES  core is processing a chunk.
- core_found  in  NUM_CORES  one-cycle pulse: core's current key passed all character checks.
- core_key  in  NUM_CORES*KEY_W  key reported by each core; core i occupies bits [i*KEY_W +: KEY_W].
- core_grant  out  NUM_CORES  one-hot, one-cycle grant pulse.
- chunk_base  out  KEY_W  first key of the granted chunk; valid while any grant bit is high.
- chunk_last  out  KEY_W  last key of the granted chunk (inclusive).
- stop_all  out  1  level; all cores must abort and return to init.
- found_key  out  1  level; valid key captured.
- key  out  KEY_W  captured key.
- last_key  out  1  level; key space exhausted with no match.
- done  out  1  level; search finished (found or exhausted).

Behaviour:
- Clock and reset: one clock, clok. Reset resetm is asynchronous and active-low.
- Reset values: all outputs 0; next_base=0; rr pointer=0; state IDLE.
- State IDLE:
  - Ignores core_req and core_found.
  - start -> DISPATCH; clears found_key, last_key, done, stop_all and key; sets next_base=0.
- State DISPATCH:
  - Each cycle, if next_base<=KEY_MAX and the masked request vector is nonzero, grant the round-robin winner.
  - Winner search starts at the index after the last granted core.
  - core_grant, chunk_base and chunk_last are registered, so a request seen in cycle t is granted in cycle t+1.
  - chunk_last = min(next_base+CHUNK_SIZE-1, KEY_MAX).
  - next_base advances by CHUNK_SIZE; it is held at KEY_W+1 bits so overflow past KEY_MAX is detected.
  - A core's req is masked in the cycle its grant is high. The core drops req the cycle after the grant.
  - When next_base>KEY_MAX: no further grants -> DRAIN.
- State DRAIN:
  - Waits for core_busy==0 and no pending grant, then -> EXHAUSTED.
- State EXHAUSTED: last_key=1, done=1. Held until reset or start.
- Any core_found in DISPATCH or DRAIN:
  - Go to FOUND next cycle; capture key from the lowest-index asserting core.
  - stop_all=1 and found_key=1 from that cycle; grants are suppressed in the same cycle.
- State FOUND: done=1 and stop_all held. Later core_found pulses are ignored; key is not overwritten.
- Simultaneous events:
  - core_found in the same cycle as a grant decision: found wins and no grant is issued.
  - start while not in IDLE is ignored, except in FOUND or EXHAUSTED, where it restarts the search.
- Reset mid-operation: immediate return to reset values. Cores see stop_all=0 and are reset by the same resetm.

Optional Feature:
- Macro: KEY_SCHED_PERF_EN.
- When defined:
  - Adds outputs chunks_granted (16 bits) and search_cycles (32 bits).
  - Both clear on start. chunks_granted increments per grant. search_cycles increments every cycle in DISPATCH or DRAIN.
  - Both saturate at all-ones and freeze in FOUND or EXHAUSTED.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package key_sched_pkg:
  - key_t (logic [KEY_W-1:0]).
  - sched_state_t enum {IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED}.
  - Default KEY_MAX and CHUNK_SIZE constants.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, advance. Outputs: one-hot gnt, gnt_idx.
  - Pointer updates on advance.
  - Scheduler instantiates one.

Test Plan:
- Basic dispatch: CHUNK_SIZE=4096, 4 cores all requesting after start -> grants to cores 0,1,2,3 on consecutive cycles. chunk_base is 0, 4096, 8192, 12288; chunk_last is base+4095.
- Found: core 2 pulses core_found with core_key=24'h0A0281 -> next cycle found_key=1, key=24'h0A0281, stop_all=1, done=1, no further grants.
- Simultaneous found: cores 1 and 3 pulse in the same cycle with keys 24'h000100 and 24'h000200 -> key=24'h000100. A later pulse from core 0 leaves key unchanged.
- Truncated last chunk: KEY_MAX=24'h00100F, CHUNK_SIZE=4096 -> second grant has chunk_base=24'h001000 and chunk_last=24'h00100F. No third grant. After core_busy falls to 0: last_key=1, done=1.
- Fairness: cores 0 and 1 request continuously, core 0 re-requesting immediately after each grant -> grants alternate 0,1,0,1.
- Reset mid-search: drive resetm low while in DISPATCH -> all outputs 0 asynchronously. After release, start restarts with chunk_base=0.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and defaults for the RC4 key-search work scheduler.
//   key_t          : key word at the default key width
//   sched_state_t  : scheduler FSM states
//   KEY_MAX_DEFAULT, CHUNK_SIZE_DEFAULT : default search range and chunk size
package key_sched_pkg;

  localparam int KEY_W_DEFAULT = 24;

  typedef logic [KEY_W_DEFAULT-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } sched_state_t;

  localparam key_t KEY_MAX_DEFAULT    = 24'h3FFFFF;
  localparam int   CHUNK_SIZE_DEFAULT = 4096;

endpackage

// File: rtl/key_search_scheduler_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter).
// Ports:
//   clok, resetm : clock, asynchronous active-low reset
//   req     [N]  : request vector (already masked by the caller)
//   advance      : the current winner was actually granted; move the pointer
//   gnt     [N]  : one-hot combinational winner (zero when no request)
//   gnt_idx      : index of the winner
// The pointer holds the index where the next search begins; after a grant
// it moves to the slot just past the winner, so a continuously requesting
// core cannot starve its neighbours.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clok,
  input  logic                 resetm,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          hit;
  int            j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!hit && req[j]) begin
        hit     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/key_search_scheduler.sv
// Dynamic work distributor for parallel RC4 key-search cores.
// Hands out contiguous key chunks round-robin, tracks the global next-key
// pointer, and collects found / exhausted status. Any found report stops
// every core.
// Ports:
//   clok, resetm        : clock, asynchronous active-low reset
//   start               : one-cycle pulse, begin a search from key 0
//   core_req/busy/found : per-core request, busy level, found pulse
//   core_key            : per-core reported key, core i at [i*KEY_W +: KEY_W]
//   core_grant          : one-hot one-cycle grant pulse
//   chunk_base/last     : inclusive key range of the granted chunk
//   stop_all            : level, all cores abort
//   found_key, key      : level, captured key
//   last_key            : level, key space exhausted with no match
//   done                : level, search finished
//   dbg_state           : current FSM state
// Optional build macro KEY_SCHED_PERF_EN adds chunks_granted and
// search_cycles saturating counters.
//
// Handshake: a core raises core_req and holds it until it sees its
// core_grant bit. The grant is registered, so a request sampled at one edge
// is granted at the next; during the grant cycle the core's request is
// masked, and the core drops (or re-raises) req from the following cycle.
// chunk_base/chunk_last are valid while any grant bit is high.
module key_search_scheduler
  import key_sched_pkg::*;
#(
  parameter int               NUM_CORES  = 4,
  parameter int               KEY_W      = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_MAX    = KEY_MAX_DEFAULT,
  parameter int               CHUNK_SIZE = CHUNK_SIZE_DEFAULT
) (
  input  logic                       clok,
  input  logic                       resetm,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_req,
  input  logic [NUM_CORES-1:0]       core_busy,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]       core_grant,
  output logic [KEY_W-1:0]           chunk_base,
  output logic [KEY_W-1:0]           chunk_last,
  output logic                       stop_all,
  output logic                       found_key,
  output logic [KEY_W-1:0]           key,
  output logic                       last_key,
  output logic                       done,
  output sched_state_t               dbg_state
`ifdef KEY_SCHED_PERF_EN
  ,
  output logic [15:0]                chunks_granted,
  output logic [31:0]                search_cycles
`endif
);

  localparam int             IDX_W       = $clog2(NUM_CORES);
  localparam logic [KEY_W:0] KEY_MAX_EXT = {1'b0, KEY_MAX};
  localparam logic [KEY_W:0] CHUNK_EXT   = (KEY_W + 1)'(CHUNK_SIZE);

  sched_state_t          state, state_n;
  // One extra bit so stepping past KEY_MAX (or past the top of the key
  // width) is seen as "out of range" rather than wrapping to zero.
  logic [KEY_W:0]        next_base, next_base_n;
  logic [NUM_CORES-1:0]  grant_n;
  logic [KEY_W-1:0]      chunk_base_n, chunk_last_n;
  logic                  stop_n, found_n, last_n, done_n;
  logic [KEY_W-1:0]      key_n;

  logic [NUM_CORES-1:0]  masked_req;
  logic [NUM_CORES-1:0]  arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  advance;
  logic                  restart;
  logic                  any_found;
  logic [KEY_W-1:0]      found_sel;
  logic [KEY_W:0]        last_ext;
  logic                  in_range;

  assign masked_req = core_req & ~core_grant;
  assign any_found  = |core_found;
  assign last_ext   = next_base + CHUNK_EXT - 1'b1;
  assign in_range   = (next_base <= KEY_MAX_EXT);
  assign dbg_state  = state;

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_arb (
    .clok    (clok),
    .resetm  (resetm),
    .req     (masked_req),
    .advance (advance),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Lowest-index reporting core wins when several report together.
  always_comb begin
    found_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) found_sel = core_key[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    state_n      = state;
    next_base_n  = next_base;
    grant_n      = '0;
    chunk_base_n = chunk_base;
    chunk_last_n = chunk_last;
    stop_n       = stop_all;
    found_n      = found_key;
    key_n        = key;
    last_n       = last_key;
    done_n       = done;
    advance      = 1'b0;
    restart      = 1'b0;

    case (state)
      IDLE: begin
        if (start) restart = 1'b1;
      end
      DISPATCH: begin
        if (any_found) begin
          state_n = FOUND;
          key_n   = found_sel;
          found_n = 1'b1;
          stop_n  = 1'b1;
          done_n  = 1'b1;
        end else if (!in_range) begin
          state_n = DRAIN;
        end else if (|arb_gnt) begin
          grant_n[arb_idx] = 1'b1;
          chunk_base_n     = next_base[KEY_W-1:0];
          chunk_last_n     = (last_ext > KEY_MAX_EXT) ? KEY_MAX : last_ext[KEY_W-1:0];
          next_base_n      = next_base + CHUNK_EXT;
          advance          = 1'b1;
        end
      end
      DRAIN: begin
        if (any_found) begin
          state_n = FOUND;
          key_n   = found_sel;
          found_n = 1'b1;
          stop_n  = 1'b1;
          done_n  = 1'b1;
        end else if (core_busy == '0 && core_grant == '0) begin
          state_n = EXHAUSTED;
          last_n  = 1'b1;
          done_n  = 1'b1;
        end
      end
      FOUND, EXHAUSTED: begin
        if (start) restart = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (restart) begin
      state_n     = DISPATCH;
      next_base_n = '0;
      found_n     = 1'b0;
      last_n      = 1'b0;
      done_n      = 1'b0;
      stop_n      = 1'b0;
      key_n       = '0;
    end
  end

  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) begin
      state      <= IDLE;
      next_base  <= '0;
      core_grant <= '0;
      chunk_base <= '0;
      chunk_last <= '0;
      stop_all   <= 1'b0;
      found_key  <= 1'b0;
      key        <= '0;
      last_key   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      next_base  <= next_base_n;
      core_grant <= grant_n;
      chunk_base <= chunk_base_n;
      chunk_last <= chunk_last_n;
      stop_all   <= stop_n;
      found_key  <= found_n;
      key        <= key_n;
      last_key   <= last_n;
      done       <= done_n;
    end
  end

`ifdef KEY_SCHED_PERF_EN
  // Counters only move in DISPATCH/DRAIN, so they freeze once finished.
  always_ff @(posedge clok or negedge resetm) begin
    if (!resetm) begin
      chunks_granted <= '0;
      search_cycles  <= '0;
    end else if (restart) begin
      chunks_granted <= '0;
      search_cycles  <= '0;
    end else begin
      if (advance && chunks_granted != '1) chunks_granted <= chunks_granted + 1'b1;
      if ((state == DISPATCH || state == DRAIN) && search_cycles != '1)
        search_cycles <= search_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler. Instance u_a uses the default
// key range; instance u_b uses a short range (KEY_MAX=24'h00100F) so the
// truncated final chunk and the exhausted path are reachable quickly.
module tb_key_search_scheduler;
  import key_sched_pkg::*;

  localparam int NC = 4;
  localparam int KW = 24;

  logic clok;
  logic resetm;

  logic            a_start, b_start;
  logic [NC-1:0]   a_req, a_busy, a_found, b_req, b_busy, b_found;
  logic [NC*KW-1:0] a_key, b_key;
  logic [NC-1:0]   a_grant, b_grant;
  logic [KW-1:0]   a_base, a_last, a_fkey, b_base, b_last, b_fkey;
  logic            a_stop, a_fnd, a_lastk, a_done;
  logic            b_stop, b_fnd, b_lastk, b_done;
  sched_state_t    a_state, b_state;
`ifdef KEY_SCHED_PERF_EN
  logic [15:0]     a_cg, b_cg;
  logic [31:0]     a_sc, b_sc;
`endif

  int errors = 0;
  int checks = 0;

  key_search_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .KEY_MAX(24'h3FFFFF), .CHUNK_SIZE(4096)) u_a (
    .clok(clok), .resetm(resetm), .start(a_start), .core_req(a_req), .core_busy(a_busy),
    .core_found(a_found), .core_key(a_key), .core_grant(a_grant), .chunk_base(a_base),
    .chunk_last(a_last), .stop_all(a_stop), .found_key(a_fnd), .key(a_fkey),
    .last_key(a_lastk), .done(a_done), .dbg_state(a_state)
`ifdef KEY_SCHED_PERF_EN
    , .chunks_granted(a_cg), .search_cycles(a_sc)
`endif
  );

  key_search_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .KEY_MAX(24'h00100F), .CHUNK_SIZE(4096)) u_b (
    .clok(clok), .resetm(resetm), .start(b_start), .core_req(b_req), .core_busy(b_busy),
    .core_found(b_found), .core_key(b_key), .core_grant(b_grant), .chunk_base(b_base),
    .chunk_last(b_last), .stop_all(b_stop), .found_key(b_fnd), .key(b_fkey),
    .last_key(b_lastk), .done(b_done), .dbg_state(b_state)
`ifdef KEY_SCHED_PERF_EN
    , .chunks_granted(b_cg), .search_cycles(b_sc)
`endif
  );

  // Clock / reset
  initial begin
    clok = 1'b0;
    forever #5 clok = ~clok;
  end

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clok);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (a_grant !== 4'b0 || a_base !== 24'h0 || a_last !== 24'h0) begin errors++;
      $display("FAIL reset_a_grant: got grant=%b base=%h last=%h expected 0 0 0", a_grant, a_base, a_last); end
    checks++; if ({a_stop, a_fnd, a_lastk, a_done} !== 4'b0 || a_fkey !== 24'h0) begin errors++;
      $display("FAIL reset_a_flags: got %b key=%h expected 0000 key=0", {a_stop, a_fnd, a_lastk, a_done}, a_fkey); end
    checks++; if (a_state !== IDLE || b_state !== IDLE) begin errors++;
      $display("FAIL reset_state: got a=%0d b=%0d expected %0d", a_state, b_state, IDLE); end
    checks++; if ({b_grant, b_stop, b_fnd, b_lastk, b_done} !== 8'b0) begin errors++;
      $display("FAIL reset_b_outputs: got %b expected 0", {b_grant, b_stop, b_fnd, b_lastk, b_done}); end
  endtask

  task automatic test_basic_dispatch();
    logic [NC-1:0] req_v;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    req_v = 4'hF;
    a_req = req_v;
    for (int i = 0; i < NC; i++) begin
      step();
      checks++; if (a_grant !== 4'(1 << i)) begin errors++;
        $display("FAIL basic_grant%0d: got %b expected %b", i, a_grant, 4'(1 << i)); end
      checks++; if (a_base !== 24'(i * 4096) || a_last !== 24'(i * 4096 + 4095)) begin errors++;
        $display("FAIL basic_chunk%0d: got %h..%h expected %h..%h", i, a_base, a_last, 24'(i * 4096), 24'(i * 4096 + 4095)); end
      // Core granted in the previous cycle drops its request now.
      if (i > 0) req_v[i-1] = 1'b0;
      a_req = req_v;
    end
    // Only core 3 still requests, and it is masked during its grant cycle.
    step();
    checks++; if (a_grant !== 4'b0) begin errors++;
      $display("FAIL basic_masked: got %b expected 0000", a_grant); end
    a_req = '0;
`ifdef KEY_SCHED_PERF_EN
    checks++; if (a_cg !== 16'd4 || a_sc !== 32'd5) begin errors++;
      $display("FAIL basic_perf: got cg=%0d sc=%0d expected 4 5", a_cg, a_sc); end
`endif
  endtask

  task automatic test_found();
    a_key = '0;
    a_key[0*KW +: KW] = 24'h111111;
    a_key[2*KW +: KW] = 24'h0A0281;
    a_found = 4'b0100;
    a_req   = 4'hF;     // found must win over a grant in the same cycle
    step();
    a_found = '0;
    checks++; if (a_fnd !== 1'b1 || a_fkey !== 24'h0A0281) begin errors++;
      $display("FAIL found_key: got %b %h expected 1 0a0281", a_fnd, a_fkey); end
    checks++; if (a_stop !== 1'b1 || a_done !== 1'b1 || a_lastk !== 1'b0) begin errors++;
      $display("FAIL found_flags: got stop=%b done=%b last=%b expected 1 1 0", a_stop, a_done, a_lastk); end
    checks++; if (a_grant !== 4'b0) begin errors++;
      $display("FAIL found_no_grant: got %b expected 0000", a_grant); end
    step();
    checks++; if (a_grant !== 4'b0 || a_state !== FOUND) begin errors++;
      $display("FAIL found_hold: got grant=%b state=%0d expected 0000 %0d", a_grant, a_state, FOUND); end
    a_req = '0;
  endtask

  task automatic test_simultaneous_found();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    checks++; if ({a_fnd, a_stop, a_done} !== 3'b0 || a_fkey !== 24'h0 || a_state !== DISPATCH) begin errors++;
      $display("FAIL restart_clear: got %b key=%h state=%0d expected 000 0 %0d", {a_fnd, a_stop, a_done}, a_fkey, a_state, DISPATCH); end
    a_key = '0;
    a_key[1*KW +: KW] = 24'h000100;
    a_key[3*KW +: KW] = 24'h000200;
    a_found = 4'b1010;
    step();
    checks++; if (a_fkey !== 24'h000100 || a_fnd !== 1'b1) begin errors++;
      $display("FAIL simul_lowest: got %h found=%b expected 000100 1", a_fkey, a_fnd); end
    a_key[0*KW +: KW] = 24'h000055;
    a_found = 4'b0001;
    step();
    a_found = '0;
    checks++; if (a_fkey !== 24'h000100) begin errors++;
      $display("FAIL simul_no_overwrite: got %h expected 000100", a_fkey); end
  endtask

  task automatic test_fairness();
    logic [NC-1:0] exp_g;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++; if (a_grant !== exp_g) begin errors++;
        $display("FAIL fair_grant%0d: got %b expected %b", i, a_grant, exp_g); end
    end
  endtask

  task automatic test_reset_mid_search();
    // Still in DISPATCH with requests pending from the fairness test.
    @(posedge clok);
    #3 resetm = 1'b0;
    #1;
    checks++; if (a_grant !== 4'b0 || a_base !== 24'h0 || a_last !== 24'h0 || a_fkey !== 24'h0) begin errors++;
      $display("FAIL midreset_data: got grant=%b base=%h last=%h key=%h expected 0", a_grant, a_base, a_last, a_fkey); end
    checks++; if ({a_stop, a_fnd, a_lastk, a_done} !== 4'b0 || a_state !== IDLE) begin errors++;
      $display("FAIL midreset_flags: got %b state=%0d expected 0000 %0d", {a_stop, a_fnd, a_lastk, a_done}, a_state, IDLE); end
    a_req = '0;
    step();
    resetm = 1'b1;
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_req = 4'hF;
    step();
    checks++; if (a_grant !== 4'b0001 || a_base !== 24'h0 || a_last !== 24'h000FFF) begin errors++;
      $display("FAIL midreset_restart: got %b %h..%h expected 0001 000000..000fff", a_grant, a_base, a_last); end
    a_req = '0;
  endtask

  task automatic test_truncated_last_chunk();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_req = 4'b0011;
    step();
    checks++; if (b_grant !== 4'b0001 || b_base !== 24'h0 || b_last !== 24'h000FFF) begin errors++;
      $display("FAIL trunc_first: got %b %h..%h expected 0001 000000..000fff", b_grant, b_base, b_last); end
    b_busy = 4'b0001;
    step();
    checks++; if (b_grant !== 4'b0010 || b_base !== 24'h001000 || b_last !== 24'h00100F) begin errors++;
      $display("FAIL trunc_second: got %b %h..%h expected 0010 001000..00100f", b_grant, b_base, b_last); end
    b_busy = 4'b0011;
    step();
    checks++; if (b_grant !== 4'b0 || b_state !== DRAIN) begin errors++;
      $display("FAIL trunc_no_third: got %b state=%0d expected 0000 %0d", b_grant, b_state, DRAIN); end
    step();
    checks++; if (b_lastk !== 1'b0 || b_done !== 1'b0 || b_grant !== 4'b0) begin errors++;
      $display("FAIL trunc_busy_wait: got last=%b done=%b grant=%b expected 0 0 0000", b_lastk, b_done, b_grant); end
    b_busy = '0;
    step();
    checks++; if (b_lastk !== 1'b1 || b_done !== 1'b1 || b_fnd !== 1'b0 || b_stop !== 1'b0) begin errors++;
      $display("FAIL trunc_exhausted: got last=%b done=%b found=%b stop=%b expected 1 1 0 0", b_lastk, b_done, b_fnd, b_stop); end
    step();
    checks++; if (b_state !== EXHAUSTED || b_lastk !== 1'b1) begin errors++;
      $display("FAIL trunc_hold: got state=%0d last=%b expected %0d 1", b_state, b_lastk, EXHAUSTED); end
    b_req = '0;
  endtask

  initial begin
    resetm  = 1'b0;
    a_start = 1'b0; a_req = '0; a_busy = '0; a_found = '0; a_key = '0;
    b_start = 1'b0; b_req = '0; b_busy = '0; b_found = '0; b_key = '0;
    repeat (3) @(posedge clok);
    #1;
    test_reset();
    resetm = 1'b1;
    step();
    test_basic_dispatch();
    test_found();
    test_simultaneous_found();
    test_fairness();
    test_reset_mid_search();
    test_truncated_last_chunk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
